seq_alu: RTL



---
 rtl/seq_alu_pkg.sv | 26 ++
 rtl/seq_alu_if.sv | 27 ++
 rtl/seq_alu_mul.sv | 68 ++++++
 rtl/seq_alu.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared types and constants for the sequential ALU: opcode encoding,
// flag bit positions and the handshake FSM states.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_OR  = 3'b100,
      OP_SLT = 3'b101,
      OP_SRL = 3'b110,
      OP_MUL = 3'b111
   } alu_op_e;

   localparam int F_Z   = 3;
   localparam int F_NEG = 2;
   localparam int F_C   = 1;
   localparam int F_V   = 0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_e;

endpackage

// File: rtl/seq_alu_if.sv
// Operand-side and result-side valid/ready bundle of the sequential ALU.
// The master is the decode/writeback side, the slave is the ALU.
interface seq_alu_if #(
   parameter int N = 32
) ();

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [2:0]   ALUControl;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] Result;
   logic [3:0]   flags;

   modport master (
      output in_valid, A, B, ALUControl, out_ready,
      input  in_ready, out_valid, Result, flags
   );

   modport slave (
      input  in_valid, A, B, ALUControl, out_ready,
      output in_ready, out_valid, Result, flags
   );

endinterface

// File: rtl/seq_alu_mul.sv
// Iterative unsigned multiplier: one shift-add step per cycle, LSB-first over B.
// prod presents the accumulator value being written this cycle, so it is final while done=1.
module seq_mul #(
   parameter int N = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] prod
);

   localparam int CW = $clog2(N) + 1;

   logic [2*N-1:0] acc_q, acc_d;
   logic [2*N-1:0] mcand_q, mcand_d;
   logic [N-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]  count_q, count_d;
   logic           busy_q, busy_d;
   logic           last_step;

   always_comb begin
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      busy_d    = busy_q;
      last_step = busy_q && (count_q == CW'(N - 1));

      if (start) begin
         acc_d    = '0;
         mcand_d  = {{N{1'b0}}, A};
         mplier_d = B;
         count_d  = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = last_step ? '0 : count_q + 1'b1;
         busy_d   = !last_step;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = last_step;
   assign prod = acc_d;

endmodule

// File: rtl/seq_alu.sv
// Registered, valid/ready ALU with Z/N/C/V flags. Single-cycle ops complete on the
// accepting edge; MUL hands off to seq_mul and stalls the input side for N cycles.
module seq_alu
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   seq_alu_if.slave  bus
);

   localparam int SHW = $clog2(N);

   state_e         state_q, state_d;
   logic           out_valid_q, out_valid_d;
   logic [N-1:0]   result_q, result_d;
   logic [3:0]     flags_q, flags_d;

   alu_op_e        op;
   logic           in_ready;
   logic           accept;
   logic           mul_start;
   logic           mul_busy;
   logic           mul_done;
   logic [2*N-1:0] mul_prod;

   logic           sub_mode;
   logic [N-1:0]   b_eff;
   logic [N:0]     add_full;
   logic           add_ovf;
   logic [N-1:0]   alu_res;
   logic           alu_c;
   logic           alu_v;

   logic           load_out;
   logic [N-1:0]   fin_res;
   logic           fin_c;
   logic           fin_v;

   assign op        = alu_op_e'(bus.ALUControl);
   assign in_ready  = rst_n && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
   assign accept    = bus.in_valid && in_ready;
   assign mul_start = accept && (op == OP_MUL);

   seq_mul #(.N(N)) u_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .start (mul_start),
      .A     (bus.A),
      .B     (bus.B),
      .busy  (mul_busy),
      .done  (mul_done),
      .prod  (mul_prod)
   );

   // SLT shares the subtractor; its less-than bit is sign corrected by the overflow term.
   always_comb begin : datapath
      sub_mode = (op == OP_SUB) || (op == OP_SLT);
      b_eff    = sub_mode ? ~bus.B : bus.B;
      add_full = {1'b0, bus.A} + {1'b0, b_eff} + {{N{1'b0}}, sub_mode};
      add_ovf  = (bus.A[N-1] == b_eff[N-1]) && (add_full[N-1] != bus.A[N-1]);
      alu_res  = '0;
      alu_c    = 1'b0;
      alu_v    = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            alu_res = add_full[N-1:0];
            alu_c   = add_full[N];
            alu_v   = add_ovf;
         end
         OP_AND:  alu_res = bus.A & bus.B;
         OP_XOR:  alu_res = bus.A ^ bus.B;
         OP_OR:   alu_res = bus.A | bus.B;
         OP_SLT:  alu_res = {{(N-1){1'b0}}, add_full[N-1] ^ add_ovf};
         OP_SRL:  alu_res = bus.A >> bus.B[SHW-1:0];
         OP_MUL:  alu_res = '0;
      endcase
   end

   always_comb begin : fsm
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      load_out    = 1'b0;
      fin_res     = alu_res;
      fin_c       = alu_c;
      fin_v       = alu_v;

      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (op == OP_MUL) begin
                  state_d = S_MUL;
               end else begin
                  load_out = 1'b1;
               end
            end
         end
         S_MUL: begin
            if (mul_done) begin
               load_out = 1'b1;
               fin_res  = mul_prod[N-1:0];
               fin_c    = 1'b0;
               fin_v    = |mul_prod[2*N-1:N];
               state_d  = S_IDLE;
            end else if (!mul_busy) begin
               state_d  = S_IDLE;
            end
         end
      endcase

      if (load_out) begin
         result_d       = fin_res;
         flags_d[F_Z]   = (fin_res == '0);
         flags_d[F_NEG] = fin_res[N-1];
         flags_d[F_C]   = fin_c;
         flags_d[F_V]   = fin_v;
         out_valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.Result    = result_q;
   assign bus.flags     = flags_q;

endmodule
